// File: rtl/keyed_xor_mux_lock_if.sv
// keyed_xor_mux_lock_if: serial key load, datapath input and registered result signals of the lock stage
interface keyed_xor_mux_lock_if #(parameter int DATA_W = 27);
  localparam int KEY_W = DATA_W + 4;
  localparam int CW = $clog2(KEY_W + 1);
  logic key_valid;
  logic key_bit;
  logic key_ready;
  logic key_clear;
  logic key_armed;
  logic in_valid;
  logic [DATA_W-1:0] data_in;
  logic sel_a;
  logic sel_b;
  logic out_valid;
  logic [DATA_W-1:0] data_out;
  logic mux_out;
  logic [CW-1:0] load_cnt;
  modport master (
    output key_valid, key_bit, key_clear, in_valid, data_in, sel_a, sel_b,
    input key_ready, key_armed, out_valid, data_out, mux_out, load_cnt
  );
  modport slave (
    input key_valid, key_bit, key_clear, in_valid, data_in, sel_a, sel_b,
    output key_ready, key_armed, out_valid, data_out, mux_out, load_cnt
  );
endinterface

// File: rtl/keyed_xor_mux_lock.sv
// keyed_xor_mux_lock: serially loaded key drives an XOR key vector and a 4-input MUX key gate
module keyed_xor_mux_lock #(parameter int DATA_W = 27) (
  input logic clk,
  input logic rst_n,
  keyed_xor_mux_lock_if.slave bus
);
  localparam int KEY_W = DATA_W + 4;
  localparam int CW = $clog2(KEY_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ARMED} state_t;
  state_t state_q, state_d;
  logic [KEY_W-1:0] shift_q, shift_d, key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic key_ready_q, key_ready_d, key_armed_q, key_armed_d;
  logic out_valid_q, out_valid_d, mux_out_q, mux_out_d;
  logic hs, fire, clr;
  logic [3:0] p;
  always_comb begin
    p = key_q[KEY_W-1:DATA_W];
    hs = key_ready_q && bus.key_valid && !bus.key_clear;
    fire = state_q == ARMED && bus.in_valid;
    clr = bus.key_clear && state_q != IDLE;
    state_d = state_q == IDLE ? LOAD :
              state_q == COMMIT ? ARMED :
              (hs && cnt_q == CW'(KEY_W - 1)) ? COMMIT : state_q;
    shift_d = hs ? {shift_q[KEY_W-2:0], bus.key_bit} : shift_q;
    cnt_d = (hs && cnt_q != CW'(KEY_W)) ? cnt_q + CW'(1) : cnt_q;
    key_d = state_q == COMMIT ? shift_q : key_q;
    out_valid_d = fire;
    data_out_d = fire ? bus.data_in ^ key_q[DATA_W-1:0] : data_out_q;
    mux_out_d = fire ? p[{bus.sel_b, bus.sel_a}] : mux_out_q;
    // clear drops any in-flight key bit and suppresses a result registered this cycle
    if (clr) begin
      state_d = LOAD;
      shift_d = '0;
      key_d = '0;
      cnt_d = '0;
      out_valid_d = 1'b0;
      data_out_d = '0;
      mux_out_d = 1'b0;
    end
    key_ready_d = state_d == LOAD;
    key_armed_d = state_d == ARMED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      key_q <= '0;
      cnt_q <= '0;
      key_ready_q <= 1'b0;
      key_armed_q <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
      mux_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
      key_ready_q <= key_ready_d;
      key_armed_q <= key_armed_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
      mux_out_q <= mux_out_d;
    end
  end
  assign bus.key_ready = key_ready_q;
  assign bus.key_armed = key_armed_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out = data_out_q;
  assign bus.mux_out = mux_out_q;
  assign bus.load_cnt = cnt_q;
endmodule

// File: tb/tb_keyed_xor_mux_lock.sv
// tb_keyed_xor_mux_lock: directed vectors with hand-computed results for 27-bit and 8-bit lock stages
module tb_keyed_xor_mux_lock;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [30:0] k1 = {4'b1010, 27'h5A5A5A5};
  logic [30:0] k2 = {4'b0110, 27'h1234567};
  logic [11:0] k8 = {4'b1010, 8'hA5};
  logic [3:0] pk1 = 4'b1010;
  keyed_xor_mux_lock_if #(.DATA_W(27)) b();
  keyed_xor_mux_lock_if #(.DATA_W(8)) b8();
  keyed_xor_mux_lock #(.DATA_W(27)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  keyed_xor_mux_lock #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic load(input logic [30:0] k, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      b.key_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("cnt_gap", 64'(b.load_cnt), 64'(i));
      end
      b.key_valid = 1'b1;
      b.key_bit = k[30-i];
      tick();
    end
    b.key_valid = 1'b0;
  endtask
  initial begin
    {b.key_valid, b.key_bit, b.key_clear, b.in_valid, b.sel_a, b.sel_b} = '0;
    b.data_in = '0;
    {b8.key_valid, b8.key_bit, b8.key_clear, b8.in_valid, b8.sel_a, b8.sel_b} = '0;
    b8.data_in = '0;
    for (int i = 0; i < 3; i++) begin
      {b.key_valid, b.key_bit, b.key_clear, b.in_valid, b.sel_a, b.sel_b} = 6'($urandom);
      b.data_in = 27'($urandom);
      tick();
    end
    chk("rst_ready", 64'(b.key_ready), 0);
    chk("rst_armed", 64'(b.key_armed), 0);
    chk("rst_ovalid", 64'(b.out_valid), 0);
    chk("rst_dout", 64'(b.data_out), 0);
    chk("rst_mux", 64'(b.mux_out), 0);
    chk("rst_cnt", 64'(b.load_cnt), 0);
    {b.key_valid, b.key_bit, b.key_clear, b.in_valid, b.sel_a, b.sel_b} = '0;
    b.data_in = '0;
    rst_n = 1'b1;
    tick();
    chk("load_ready", 64'(b.key_ready), 1);
    load(k1, 31, 0);
    chk("commit_ready", 64'(b.key_ready), 0);
    chk("commit_armed", 64'(b.key_armed), 0);
    chk("commit_cnt", 64'(b.load_cnt), 31);
    tick();
    chk("armed", 64'(b.key_armed), 1);
    b.in_valid = 1'b1;
    b.data_in = 27'h7FFFFFF;
    tick();
    chk("dp_ovalid", 64'(b.out_valid), 1);
    chk("dp_dout", 64'(b.data_out), 64'h25A5A5A);
    chk("dp_mux00", 64'(b.mux_out), 0);
    for (int s = 1; s < 4; s++) begin
      {b.sel_b, b.sel_a} = 2'(s);
      tick();
      chk("sweep_ovalid", 64'(b.out_valid), 1);
      chk("sweep_mux", 64'(b.mux_out), 64'(pk1[s]));
    end
    b.in_valid = 1'b0;
    tick();
    chk("idle_ovalid", 64'(b.out_valid), 0);
    chk("idle_dout", 64'(b.data_out), 64'h25A5A5A);
    chk("idle_mux", 64'(b.mux_out), 1);
    b.key_valid = 1'b1;
    b.key_bit = 1'b1;
    tick();
    b.key_valid = 1'b0;
    chk("armed_ignore_cnt", 64'(b.load_cnt), 31);
    chk("armed_ignore_armed", 64'(b.key_armed), 1);
    b.in_valid = 1'b1;
    b.key_clear = 1'b1;
    tick();
    b.in_valid = 1'b0;
    b.key_clear = 1'b0;
    chk("clr_ovalid", 64'(b.out_valid), 0);
    chk("clr_armed", 64'(b.key_armed), 0);
    chk("clr_cnt", 64'(b.load_cnt), 0);
    chk("clr_dout", 64'(b.data_out), 0);
    chk("clr_ready", 64'(b.key_ready), 1);
    load(k2, 15, 0);
    chk("part_cnt", 64'(b.load_cnt), 15);
    b.key_clear = 1'b1;
    b.key_valid = 1'b1;
    tick();
    b.key_clear = 1'b0;
    b.key_valid = 1'b0;
    chk("clr15_cnt", 64'(b.load_cnt), 0);
    load(k2, 31, 2);
    chk("gap_cnt", 64'(b.load_cnt), 31);
    tick();
    chk("gap_armed", 64'(b.key_armed), 1);
    b.in_valid = 1'b1;
    b.data_in = 27'h0ABCDEF;
    {b.sel_b, b.sel_a} = 2'b10;
    tick();
    b.in_valid = 1'b0;
    chk("k2_dout", 64'(b.data_out), 64'h1888888);
    chk("k2_mux", 64'(b.mux_out), 1);
    b.key_clear = 1'b1;
    tick();
    b.key_clear = 1'b0;
    load(k1, 20, 0);
    chk("mid_cnt", 64'(b.load_cnt), 20);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cnt", 64'(b.load_cnt), 0);
    chk("mid_rst_ready", 64'(b.key_ready), 0);
    chk("mid_rst_armed", 64'(b.key_armed), 0);
    chk("mid_rst_dout", 64'(b.data_out), 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(b.key_ready), 1);
    load(k1, 31, 0);
    tick();
    chk("reload_armed", 64'(b.key_armed), 1);
    b.in_valid = 1'b1;
    b.data_in = 27'h0;
    {b.sel_b, b.sel_a} = 2'b11;
    tick();
    b.in_valid = 1'b0;
    chk("reload_dout", 64'(b.data_out), 64'h5A5A5A5);
    chk("reload_mux", 64'(b.mux_out), 1);
    for (int i = 0; i < 12; i++) begin
      b8.key_valid = 1'b1;
      b8.key_bit = k8[11-i];
      tick();
    end
    b8.key_valid = 1'b0;
    tick();
    chk("w8_armed", 64'(b8.key_armed), 1);
    chk("w8_cnt", 64'(b8.load_cnt), 12);
    b8.in_valid = 1'b1;
    b8.data_in = 8'hFF;
    {b8.sel_b, b8.sel_a} = 2'b01;
    tick();
    b8.in_valid = 1'b0;
    chk("w8_ovalid", 64'(b8.out_valid), 1);
    chk("w8_dout", 64'(b8.data_out), 64'h5A);
    chk("w8_mux", 64'(b8.mux_out), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
